// File: rtl/ldl_fifo_rs_v2.sv
// Read side of a FIFO that sits on an external memory: pointer, address, status and output staging.
// Latency: legacy mode passes rdata straight through; FWFT mode shows a new word 2 cycles after w_pt moves.
// Backpressure: re is honoured only while a word is available; FWFT stops fetching while its 2-entry stage is committed.
// Optional: define LDL_FIFO_RS_ERR_EN to build the sticky underflow register (otherwise underflow is tied low).
module ldl_fifo_rs_v2 #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int FWFT     = 0,
  parameter int AHEAD    = 1,
  parameter int AE_LEVEL = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          re,
  input  logic [AW:0]   w_pt,
  input  logic [DW-1:0] rdata,
  output logic          mem_re,
  output logic [AW-1:0] ra,
  output logic [AW:0]   r_pt,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          almost_empty,
  output logic [AW+1:0] rcnt,
  output logic          mr,
  output logic          underflow
);

  // Pointers carry one extra wrap bit, so a plain subtraction gives the memory count.
  logic          avail;
  logic [AW:0]   mc;

  assign mc           = w_pt - r_pt;
  assign avail        = (w_pt != r_pt);
  assign mr           = avail;
  assign almost_empty = (rcnt <= (AW+2)'(AE_LEVEL));

  generate
    if (FWFT == 0) begin : g_legacy
      logic fr;
      logic empty_q;

      assign fr     = re & ~empty_q;
      assign mem_re = fr;
      // With AHEAD the memory is already steered at the word after the one being consumed.
      assign ra     = ((AHEAD != 0) && fr) ? (r_pt[AW-1:0] + AW'(1)) : r_pt[AW-1:0];
      assign empty  = empty_q;
      assign dout   = rdata;
      assign rcnt   = {1'b0, mc};

      // Advance the read pointer on each accepted read and track the registered empty flag.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pt    <= '0;
          empty_q <= 1'b1;
        end else begin
          if (fr) begin
            r_pt <= r_pt + (AW+1)'(1);
          end
          if (fr && (mc == (AW+1)'(1))) begin
            empty_q <= 1'b1;
          end else if (avail) begin
            empty_q <= 1'b0;
          end
        end
      end
    end else begin : g_fwft
      typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
      } oc_t;

      oc_t           oc;
      logic          p;
      logic [DW-1:0] head;
      logic [DW-1:0] tail;
      logic          pop;
      logic          fetch;
      logic [1:0]    oc_num;
      logic [1:0]    post_pop;
      logic [1:0]    oc_next;

      assign oc_num   = oc;
      assign pop      = re & (oc != EMPTY);
      assign post_pop = oc_num - {1'b0, pop};
      assign oc_next  = post_pop + {1'b0, p};
      // Only fetch when the word already in flight plus this one still fit in two entries.
      // rst_n gates the fetch so the memory stays idle while reset is held.
      assign fetch    = rst_n & avail & (oc_next <= 2'd1);
      assign mem_re   = fetch;
      assign ra       = r_pt[AW-1:0];
      assign empty    = (oc == EMPTY);
      assign dout     = head;
      assign rcnt     = {1'b0, mc} + (AW+2)'(oc_num) + (AW+2)'(p);

      // Output-stage FSM: occupancy, in-flight flag, head/tail data and read pointer.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pt <= '0;
          oc   <= EMPTY;
          p    <= 1'b0;
          head <= '0;
          tail <= '0;
        end else begin
          p  <= fetch;
          oc <= oc_t'(oc_next);
          if (fetch) begin
            r_pt <= r_pt + (AW+1)'(1);
          end
          if (pop && (oc == TWO)) begin
            head <= tail;
          end
          if (p) begin
            if (post_pop == 2'd0) begin
              head <= rdata;
            end else begin
              tail <= rdata;
            end
          end
        end
      end
    end
  endgenerate

`ifdef LDL_FIFO_RS_ERR_EN
  logic underflow_q;

  // Remember any read attempted while nothing was available, until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_q <= 1'b0;
    end else if (re & empty) begin
      underflow_q <= 1'b1;
    end
  end

  assign underflow = underflow_q;
`else
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_ldl_fifo_rs_v2.sv
// Bench for ldl_fifo_rs_v2: one legacy-mode instance (AW=4, AHEAD=1) and one FWFT instance (AW=3).
// Each instance is driven at the falling edge and compared against a word-level model of what the consumer may see.
// A behavioural memory answers mem_re one cycle later.
module tb_ldl_fifo_rs_v2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Legacy instance signals
  logic       re0;
  logic [4:0] w_pt0;
  logic [7:0] rdata0;
  logic       mem_re0;
  logic [3:0] ra0;
  logic [4:0] r_pt0;
  logic [7:0] dout0;
  logic       empty0;
  logic       ae0;
  logic [5:0] rcnt0;
  logic       mr0;
  logic       uf_o0;

  // FWFT instance signals
  logic       re1;
  logic [3:0] w_pt1;
  logic [7:0] rdata1;
  logic       mem_re1;
  logic [2:0] ra1;
  logic [3:0] r_pt1;
  logic [7:0] dout1;
  logic       empty1;
  logic       ae1;
  logic [4:0] rcnt1;
  logic       mr1;
  logic       uf_o1;

  ldl_fifo_rs_v2 #(.AW(4), .DW(8), .FWFT(0), .AHEAD(1), .AE_LEVEL(1)) u_legacy (
    .clk(clk), .rst_n(rst_n), .re(re0), .w_pt(w_pt0), .rdata(rdata0),
    .mem_re(mem_re0), .ra(ra0), .r_pt(r_pt0), .dout(dout0), .empty(empty0),
    .almost_empty(ae0), .rcnt(rcnt0), .mr(mr0), .underflow(uf_o0)
  );

  ldl_fifo_rs_v2 #(.AW(3), .DW(8), .FWFT(1), .AHEAD(0), .AE_LEVEL(2)) u_fwft (
    .clk(clk), .rst_n(rst_n), .re(re1), .w_pt(w_pt1), .rdata(rdata1),
    .mem_re(mem_re1), .ra(ra1), .r_pt(r_pt1), .dout(dout1), .empty(empty1),
    .almost_empty(ae1), .rcnt(rcnt1), .mr(mr1), .underflow(uf_o1)
  );

  // Behavioural memories: data appears one cycle after the read enable.
  logic [7:0] mem0 [16];
  logic [7:0] mem1 [8];
  always @(posedge clk) if (mem_re0) rdata0 <= mem0[ra0];
  always @(posedge clk) if (mem_re1) rdata1 <= mem1[ra1];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  // Legacy model: words written / words read, registered empty, sticky underflow.
  int wr0 = 0;
  int rd0 = 0;
  bit e0  = 1'b1;
  bit ufm0 = 1'b0;

  task automatic step0(input int nwr, input bit rd);
    int cnt;
    bit fr;
    @(negedge clk);
    check("l_empty", empty0, e0);
    check("l_rpt", r_pt0, rd0 % 32);
    check("l_rcnt", rcnt0, wr0 - rd0);
    check("l_ae", ae0, (wr0 - rd0) <= 1);
    check("l_uf", uf_o0, ufm0);
    for (int k = 0; k < nwr; k++) begin
      if (wr0 - rd0 < 16) begin
        mem0[w_pt0[3:0]] = 8'($urandom);
        w_pt0 = w_pt0 + 5'd1;
        wr0++;
      end
    end
    re0 = rd;
    cnt = wr0 - rd0;
    fr  = rd & ~e0;
    #1;
    check("l_mem_re", mem_re0, fr);
    check("l_ra", ra0, (rd0 + int'(fr)) % 16);
    check("l_mr", mr0, cnt != 0);
    check("l_dout", dout0, rdata0);
`ifdef LDL_FIFO_RS_ERR_EN
    if (rd && e0) ufm0 = 1'b1;
`endif
    if (fr && cnt == 1) e0 = 1'b1;
    else if (cnt != 0)  e0 = 1'b0;
    rd0 += int'(fr);
  endtask

  // FWFT model: queue of unconsumed words with the cycle each was written;
  // a word becomes visible to the consumer two cycles after its write.
  logic [7:0] q  [$];
  int         qt [$];
  int         cyc = 0;
  bit         ufm1 = 1'b0;

  task automatic step1(input int nwr, input bit rd);
    bit vis;
    logic [3:0] d;
    logic [7:0] dat;
    @(negedge clk);
    cyc++;
    vis = (q.size() > 0) && (qt[0] + 2 <= cyc);
    check("f_empty", empty1, !vis);
    if (vis) check("f_dout", dout1, q[0]);
    check("f_rcnt", rcnt1, q.size());
    check("f_rcnt_max", rcnt1 <= 5'd10, 1);
    check("f_ae", ae1, q.size() <= 2);
    check("f_uf", uf_o1, ufm1);
    for (int k = 0; k < nwr; k++) begin
      d = w_pt1 - r_pt1;
      if (d < 4'd8) begin
        dat = 8'($urandom);
        mem1[w_pt1[2:0]] = dat;
        w_pt1 = w_pt1 + 4'd1;
        q.push_back(dat);
        qt.push_back(cyc);
      end
    end
    re1 = rd;
    if (rd && vis) begin
      void'(q.pop_front());
      void'(qt.pop_front());
    end
`ifdef LDL_FIFO_RS_ERR_EN
    if (rd && !vis) ufm1 = 1'b1;
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    re0 = 1'b0; w_pt0 = '0;
    re1 = 1'b0; w_pt1 = '0;
    #12;
    check("rst_l_empty", empty0, 1);
    check("rst_l_rpt", r_pt0, 0);
    check("rst_l_mem_re", mem_re0, 0);
    check("rst_f_empty", empty1, 1);
    check("rst_f_rcnt", rcnt1, 0);
    check("rst_f_mem_re", mem_re1, 0);
    check("rst_uf0", uf_o0, 0);
    check("rst_uf1", uf_o1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Legacy: three words land together, re held high throughout.
    step0(3, 1'b1);
    step0(0, 1'b1);
    step0(0, 1'b1);
    step0(0, 1'b1);
    step0(0, 1'b1);
    step0(0, 1'b0);
    check("l3_rpt", r_pt0, 3);
    check("l3_empty", empty0, 1);
    for (int i = 0; i < 300; i++) step0(($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 2), 1'($urandom_range(0, 1)));
    re0 = 1'b0;

    // FWFT: one word, no reads.
    step1(1, 1'b0);
    #1;
    check("f1_mem_re", mem_re1, 1);
    check("f1_ra", ra1, 0);
    step1(0, 1'b0);
    #1;
    check("f1_mem_re_idle", mem_re1, 0);
    step1(0, 1'b0);
    check("f1_rcnt", rcnt1, 1);
    check("f1_dout", dout1, mem1[0]);
    step1(0, 1'b1);
    step1(0, 1'b0);

    // FWFT: fill all eight memory words, then stream them out back to back.
    step1(8, 1'b0);
    for (int i = 0; i < 4; i++) step1(0, 1'b0);
    check("f8_rcnt", rcnt1, 8);
    for (int i = 0; i < 8; i++) step1(0, 1'b1);
    step1(0, 1'b0);
    check("f8_empty", empty1, 1);

    // FWFT random traffic, pointers wrap many times.
    for (int i = 0; i < 100; i++) step1(1, 1'b1);
    for (int i = 0; i < 300; i++) step1(($urandom_range(0, 3) != 0) ? 1 : 0, ($urandom_range(0, 3) != 0));
    for (int i = 0; i < 200; i++) step1($urandom_range(0, 3), 1'($urandom_range(0, 1)));

    // Drain, then reset while a fetch is in flight.
    for (int i = 0; i < 30; i++) step1(0, 1'b1);
    step1(3, 1'b0);
    step1(0, 1'b0);
    step1(0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("r_empty", empty1, 1);
    check("r_rcnt", rcnt1, {1'b0, w_pt1});
    check("r_rpt", r_pt1, 0);
    check("r_mem_re", mem_re1, 0);
    check("r_uf0", uf_o0, 0);
    check("r_uf1", uf_o1, 0);
    check("r_l_rpt", r_pt0, 0);
    ufm0 = 1'b0;
    ufm1 = 1'b0;
    w_pt0 = '0;
    for (int k = 0; k < 3; k++) mem1[k] = 8'(8'h11 * (k + 1));
    w_pt1 = 4'd3;
    #1;
    check("r_rcnt3", rcnt1, 3);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
    #1;
    check("r_first_mem_re", mem_re1, 1);
    check("r_first_ra", ra1, 0);
    q.delete();
    qt.delete();
    for (int k = 0; k < 3; k++) begin
      q.push_back(mem1[k]);
      qt.push_back(cyc);
    end
    for (int i = 0; i < 200; i++) step1(($urandom_range(0, 2) != 0) ? 1 : 0, ($urandom_range(0, 2) != 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ldl_fifo_rs_v2.md
LDL_FIFO_RS_V2 -- requirements
Module: ldl_fifo_rs_v2

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- AW  8  address width; memory depth 2^AW.
- DW  8  data width.
- FWFT  0  0 = legacy read mode; 1 = first-word-fall-through with 2-entry output stage.
- AHEAD  1  FWFT=0 only; 1 = ra presents next address during a read.
- AE_LEVEL  1  almost_empty threshold, in words.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- re  in  1  read request from consumer.
- w_pt  in  AW+1  write pointer, binary, same clock domain.
- rdata  in  DW  memory read data, valid 1 cycle after mem_re.
- mem_re  out  1  memory read enable.
- ra  out  AW  memory read address.
- r_pt  out  AW+1  read pointer.
- dout  out  DW  consumer data.
- empty  out  1  no word available to consumer.
- almost_empty  out  1  rcnt <= AE_LEVEL.
- rcnt  out  AW+2  words available to consumer.
- mr  out  1  memory not empty (w_pt != r_pt).
- underflow  out  1  sticky: re asserted while empty.

Function
REQ-003 avail = (w_pt != r_pt); mr = avail; memory count mc = w_pt - r_pt, modulo 2^(AW+1), so pointer wrap is transparent.
REQ-004 FWFT=0: fr = re & ~empty; mem_re = fr; ra = (AHEAD & fr) ? r_pt[AW-1:0]+1 : r_pt[AW-1:0]; r_pt increments on fr.
REQ-005 FWFT=0: empty is registered:
- Set to 1 on fr when mc==1.
- Else cleared to 0 when avail (one cycle delay after write).
- dout = rdata, passed through combinationally.
- rcnt = mc, zero-extended.
REQ-006 FWFT=1: output stage holds occupancy oc in {0,1,2} (states EMPTY, ONE, TWO), plus in-flight flag p = registered mem_re.
REQ-007 FWFT=1 pop and fetch:
- pop = re & (oc!=0).
- fetch = avail & (oc + p - pop <= 1).
- mem_re = fetch; ra = r_pt[AW-1:0]; r_pt increments on fetch.
REQ-008 FWFT=1 transitions: next oc = oc + p - pop; arriving rdata (when p) is written to the head entry if the post-pop stage is empty, else to the tail entry. Reads and arrivals in the same cycle are legal.
REQ-009 FWFT=1 outputs: dout = head entry; empty = (oc==0); rcnt = mc + oc + p. Sustained throughput SHALL be 1 word/cycle; first-word latency from the w_pt change to empty=0 SHALL be 2 cycles.
REQ-010 almost_empty SHALL be combinational from rcnt, in both modes.
REQ-011 re while empty SHALL NOT move r_pt, oc or dout.
REQ-012 The stage SHALL never hold more than 2 words; rcnt SHALL never exceed 2^AW+2.

Reset
REQ-013 rst_n=0 SHALL asynchronously force: r_pt=0, empty=1, oc=0, p=0, head/tail entries=0, underflow=0; hence mem_re=0 and rcnt=mc.
REQ-014 Reset mid-read SHALL discard in-flight rdata; the first post-reset read SHALL address 0.

Configuration
REQ-015 Macro LDL_FIFO_RS_ERR_EN, when defined: underflow sets on (re & empty) and stays set until reset.
REQ-016 Without LDL_FIFO_RS_ERR_EN: underflow is tied to 0 and no error register exists.

Verification
REQ-017 FWFT=0, AHEAD=1: w_pt 0->3, re held high -> empty falls 1 cycle later; ra sequence 1,2,3; empty=1 after the third read; r_pt=3.
REQ-018 FWFT=1: single write (w_pt 0->1), re=0 -> mem_re at cycle 1, empty=0 at cycle 2, dout=mem[0], rcnt=1.
REQ-019 FWFT=1: 8 words preloaded, re held high -> 8 consecutive pops, one per cycle, dout=mem[0..7] in order, then empty=1 with oc=0.
REQ-020 FWFT=1, AW=2: pointers wrap through 7->0 while streaming 12 words -> no lost or duplicated words; rcnt never exceeds 6.
REQ-021 LDL_FIFO_RS_ERR_EN defined: re=1 while empty -> underflow=1 next cycle, stays set, r_pt unchanged; rst_n pulsed low -> underflow=0 immediately.
REQ-022 FWFT=1: rst_n low while p=1 and oc=2 -> empty=1, rcnt=mc; the next fetch reads ra=0.
